control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle sequencer for the RV32I datapath subset (R, I-ALU, load, store, branch, LUI, AUIPC). Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several clocks, handshakes with instruction and data memories that may take extra cycles, and produces per-cycle datapath strobes. Sits between the instruction register/opcode field and the shared ALU, register file, PC and memory ports, and replaces per-instruction one-cycle control in the multicycle core.

## Interface
- No parameters; widths fixed by RV32I.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- en  in  1  global advance enable; 0 freezes FSM, write strobes forced 0.
- opcode  in  7  instruction[6:0] from instruction register, sampled in DECODE.
- branch_cond  in  1  ALU branch-condition result, valid in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  update PC.
- PCSrc  out  1  0: PC+4, 1: branch target.
- MemRead, MemWrite  out  1 each  data memory strobes.
- MemtoReg  out  1  write-back source is memory.
- ALUSrc  out  1  ALU operand B is immediate.
- RegWrite  out  1  register file write.
- Branch  out  1  branch instruction in EXEC.
- ALUOp  out  4  R 0000, I 1100, load 1110, store 0001, branch 1111, LUI 0011, AUIPC 0111.
- AuipcLui  out  2  operand A select: 10 rs1, 01 zero (LUI), 00 PC (AUIPC).
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- busy  out  1  high in every state except FETCH-waiting.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Next state registered; outputs Moore-decoded from state plus latched opcode (opc_q).
- FETCH: imem_req=1. If imem_ready: IRWrite=1, go DECODE; else hold.
- DECODE: opc_q <= opcode. Supported: go EXEC. Unsupported: illegal_op=1, PCWrite=1, PCSrc=0, go FETCH.
- EXEC: ALUOp/ALUSrc/AuipcLui per opc_q (default ALUOp 0000, AuipcLui 10). Branch: Branch=1, PCWrite=1, PCSrc=branch_cond, go FETCH. Load/store: go MEM. Others: go WB.
- MEM: load MemRead=1, store MemWrite=1, held until dmem_ready. On ready: store gets PCWrite=1, PCSrc=0, go FETCH; load goes WB.
- WB: RegWrite=1, MemtoReg=1 only for load, PCWrite=1, PCSrc=0, go FETCH.
- ALUOp/ALUSrc/AuipcLui remain driven in MEM and WB for the current instruction.
- en=0: state and opc_q hold; IRWrite, PCWrite, RegWrite, MemWrite, illegal_op forced 0; MemRead and imem_req hold their levels.
- ready inputs ignored outside the state that consumes them.

## Timing
- RESET high at an edge: state=FETCH, opc_q=0. All outputs are 0 while RESET is high, overriding state decode. This includes imem_req and AuipcLui=00.
- Reset mid-instruction aborts it; no write strobe occurs in the reset cycle.
- Zero-wait latency (ready high on first request): branch 3 cycles; R/I/LUI/AUIPC/store 4 cycles; load 5 cycles. Each memory wait cycle adds 1.
- Exactly one PCWrite per instruction, in its final cycle.
- en=0 coinciding with ready: the ready is not consumed; the FSM re-samples ready after en returns.

## Structure
- Package ctrl_mc_pkg: state enum, opcode localparams (0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111), ALUOp and AuipcLui code constants.
- Sub-module decod_opcode: combinational opc_q → instruction class, ALUOp, ALUSrc, AuipcLui, legal flag.
- Top holds the state register, opc_q, next-state logic and strobe decode.

## Test plan
- R-type 0110011, ready always 1: cycles show IRWrite, –, ALUOp=0000, RegWrite+PCWrite; MemtoReg=0 throughout.
- Load 0000011 with dmem_ready low 2 cycles: MemRead high 3 cycles, then WB with RegWrite=1, MemtoReg=1; total 7 cycles.
- Branch 1100011: with branch_cond=1, EXEC gives PCWrite=1, PCSrc=1, Branch=1, ALUOp=1111; with branch_cond=0, PCSrc=0; 3 cycles each, no RegWrite.
- Opcode 1111111: DECODE shows illegal_op=1, PCWrite=1, then back to FETCH; no RegWrite or MemWrite.
- Store in MEM with en=0 for 2 cycles while dmem_ready=1: MemWrite=0 and state held; on en=1 → PCWrite, FETCH.
- RESET asserted in WB of LUI: RegWrite=0 that cycle, all outputs 0, next state FETCH; LUI flow gives AuipcLui=01 and ALUOp=0011; AUIPC flow gives 00 and 0111.

Source files
------------

// File: rtl/ctrl_mc_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_mc_pkg : shared constants for the RV32I multicycle control sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ctrl_mc_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   typedef enum logic [2:0] {
      C_ALU     = 3'd0,
      C_LOAD    = 3'd1,
      C_STORE   = 3'd2,
      C_BRANCH  = 3'd3,
      C_ILLEGAL = 3'd4
   } instr_class_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALUOP_R      = 4'b0000;
   localparam logic [3:0] ALUOP_I      = 4'b1100;
   localparam logic [3:0] ALUOP_LOAD   = 4'b1110;
   localparam logic [3:0] ALUOP_STORE  = 4'b0001;
   localparam logic [3:0] ALUOP_BRANCH = 4'b1111;
   localparam logic [3:0] ALUOP_LUI    = 4'b0011;
   localparam logic [3:0] ALUOP_AUIPC  = 4'b0111;

   localparam logic [1:0] ASEL_RS1  = 2'b10;
   localparam logic [1:0] ASEL_ZERO = 2'b01;
   localparam logic [1:0] ASEL_PC   = 2'b00;

endpackage

`default_nettype wire

// File: rtl/decod_opcode.sv
// ----------------------------------------------------------------------------
// decod_opcode : opcode -> instruction class and ALU operand controls
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decod_opcode
   import ctrl_mc_pkg::*;
(
   input  logic [6:0] opc,
   output logic [2:0] cls,
   output logic [3:0] alu_op,
   output logic       alu_src,
   output logic [1:0] auipc_lui,
   output logic       legal
);

   always_comb begin
      cls       = C_ILLEGAL;
      alu_op    = ALUOP_R;
      alu_src   = 1'b0;
      auipc_lui = ASEL_RS1;
      legal     = 1'b1;
      case (opc)
         OPC_R: begin
            cls = C_ALU;
         end
         OPC_I: begin
            cls     = C_ALU;
            alu_op  = ALUOP_I;
            alu_src = 1'b1;
         end
         OPC_LOAD: begin
            cls     = C_LOAD;
            alu_op  = ALUOP_LOAD;
            alu_src = 1'b1;
         end
         OPC_STORE: begin
            cls     = C_STORE;
            alu_op  = ALUOP_STORE;
            alu_src = 1'b1;
         end
         OPC_BRANCH: begin
            cls    = C_BRANCH;
            alu_op = ALUOP_BRANCH;
         end
         OPC_LUI: begin
            cls       = C_ALU;
            alu_op    = ALUOP_LUI;
            alu_src   = 1'b1;
            auipc_lui = ASEL_ZERO;
         end
         OPC_AUIPC: begin
            cls       = C_ALU;
            alu_op    = ALUOP_AUIPC;
            alu_src   = 1'b1;
            auipc_lui = ASEL_PC;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
// ----------------------------------------------------------------------------
// control_multiciclo : FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module control_multiciclo
   import ctrl_mc_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       en,
   input  logic [6:0] opcode,
   input  logic       branch_cond,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       ALUSrc,
   output logic       RegWrite,
   output logic       Branch,
   output logic [3:0] ALUOp,
   output logic [1:0] AuipcLui,
   output logic       illegal_op,
   output logic       busy
);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [6:0] opc_q;
   logic [6:0] dec_opc;
   logic [2:0] cls;
   logic [3:0] dec_alu_op;
   logic       dec_alu_src;
   logic [1:0] dec_auipc_lui;
   logic       dec_legal;
   logic       is_load;
   logic       is_store;
   logic       is_branch;

   // DECODE must judge legality before opc_q has captured the opcode
   assign dec_opc = (state == S_DECODE) ? opcode : opc_q;

   decod_opcode u_dec (
      .opc       (dec_opc),
      .cls       (cls),
      .alu_op    (dec_alu_op),
      .alu_src   (dec_alu_src),
      .auipc_lui (dec_auipc_lui),
      .legal     (dec_legal)
   );

   assign is_load   = (cls == C_LOAD);
   assign is_store  = (cls == C_STORE);
   assign is_branch = (cls == C_BRANCH);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_FETCH;
         opc_q <= 7'd0;
      end else if (en) begin
         state <= state_nx;
         if (state == S_DECODE) begin
            opc_q <= opcode;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (imem_ready) state_nx = S_DECODE;
         S_DECODE: state_nx = dec_legal ? S_EXEC : S_FETCH;
         S_EXEC: begin
            if (is_branch)                 state_nx = S_FETCH;
            else if (is_load || is_store)  state_nx = S_MEM;
            else                           state_nx = S_WB;
         end
         S_MEM:    if (dmem_ready) state_nx = is_load ? S_WB : S_FETCH;
         S_WB:     state_nx = S_FETCH;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      ALUOp      = ALUOP_R;
      AuipcLui   = ASEL_RS1;
      illegal_op = 1'b0;
      busy       = 1'b1;
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
         ALUOp    = dec_alu_op;
         ALUSrc   = dec_alu_src;
         AuipcLui = dec_auipc_lui;
      end
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            IRWrite  = imem_ready;
            busy     = imem_ready;
         end
         S_DECODE: begin
            illegal_op = !dec_legal;
            PCWrite    = !dec_legal;
         end
         S_EXEC: begin
            Branch  = is_branch;
            PCWrite = is_branch;
            PCSrc   = is_branch && branch_cond;
         end
         S_MEM: begin
            MemRead  = is_load;
            MemWrite = is_store;
            PCWrite  = is_store && dmem_ready;
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = is_load;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
      if (!en) begin
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemWrite   = 1'b0;
         illegal_op = 1'b0;
      end
      // Reset dominates every output, including the select fields
      if (RESET) begin
         imem_req   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         PCSrc      = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         MemtoReg   = 1'b0;
         ALUSrc     = 1'b0;
         RegWrite   = 1'b0;
         Branch     = 1'b0;
         ALUOp      = 4'b0000;
         AuipcLui   = 2'b00;
         illegal_op = 1'b0;
         busy       = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
// ----------------------------------------------------------------------------
// tb_control_multiciclo : directed per-cycle vectors checked through a scoreboard
// Revision              : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_control_multiciclo;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [6:0] opcode;
   logic       branch_cond;
   logic       imem_ready;
   logic       dmem_ready;
   logic       imem_req, IRWrite, PCWrite, PCSrc, MemRead, MemWrite;
   logic       MemtoReg, ALUSrc, RegWrite, Branch, illegal_op, busy;
   logic [3:0] ALUOp;
   logic [1:0] AuipcLui;

   always #5 clk = ~clk;

   control_multiciclo dut (
      .CLK         (clk),
      .RESET       (rst),
      .en          (en),
      .opcode      (opcode),
      .branch_cond (branch_cond),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCSrc       (PCSrc),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .ALUSrc      (ALUSrc),
      .RegWrite    (RegWrite),
      .Branch      (Branch),
      .ALUOp       (ALUOp),
      .AuipcLui    (AuipcLui),
      .illegal_op  (illegal_op),
      .busy        (busy)
   );

   localparam logic [17:0] IMR  = 18'h1 << 17;
   localparam logic [17:0] IRW  = 18'h1 << 16;
   localparam logic [17:0] PCW  = 18'h1 << 15;
   localparam logic [17:0] PCS  = 18'h1 << 14;
   localparam logic [17:0] MR   = 18'h1 << 13;
   localparam logic [17:0] MW   = 18'h1 << 12;
   localparam logic [17:0] M2R  = 18'h1 << 11;
   localparam logic [17:0] ASRC = 18'h1 << 10;
   localparam logic [17:0] RW   = 18'h1 << 9;
   localparam logic [17:0] BR   = 18'h1 << 8;
   localparam logic [17:0] ILL  = 18'h1 << 1;
   localparam logic [17:0] BSY  = 18'h1;
   localparam logic [6:0]  JUNK = 7'b1111111;

   function automatic logic [17:0] fld(input logic [3:0] op, input logic [1:0] asel);
      return {10'd0, op, asel, 2'b00};
   endfunction

   typedef struct {
      logic [17:0] exp;
      string       tag;
   } item_t;

   item_t q[$];
   int    total = 0;
   int    bad   = 0;

   wire [17:0] act = {imem_req, IRWrite, PCWrite, PCSrc, MemRead, MemWrite,
                      MemtoReg, ALUSrc, RegWrite, Branch, ALUOp, AuipcLui,
                      illegal_op, busy};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         it = q.pop_front();
         total++;
         if (act !== it.exp) begin
            bad++;
            $display("FAIL %s: got %05h want %05h", it.tag, act, it.exp);
         end
      end
   end

   task automatic cyc(input logic r, input logic e, input logic [6:0] op,
                      input logic bc, input logic ir, input logic dr,
                      input logic [17:0] exp, input string tag);
      item_t it;
      rst = r; en = e; opcode = op; branch_cond = bc;
      imem_ready = ir; dmem_ready = dr;
      it.exp = exp;
      it.tag = tag;
      q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   localparam logic [17:0] DEF = 18'h8;

   initial begin
      rst = 1'b1; en = 1'b1; opcode = JUNK; branch_cond = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc(1, 1, JUNK, 0, 1, 1, 18'h0, "reset0");
      cyc(1, 1, JUNK, 0, 1, 1, 18'h0, "reset1");

      // R-type, zero wait, preceded by one fetch wait cycle
      cyc(0, 1, JUNK, 0, 0, 0, IMR | DEF, "fetch_wait");
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "r_fetch");
      cyc(0, 1, 7'b0110011, 0, 0, 0, BSY | DEF, "r_decode");
      cyc(0, 1, JUNK, 0, 0, 0, BSY | fld(4'b0000, 2'b10), "r_exec");
      cyc(0, 1, JUNK, 0, 0, 0, RW | PCW | BSY | fld(4'b0000, 2'b10), "r_wb");

      // I-type ALU
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "i_fetch");
      cyc(0, 1, 7'b0010011, 0, 0, 0, BSY | DEF, "i_decode");
      cyc(0, 1, JUNK, 0, 0, 0, ASRC | BSY | fld(4'b1100, 2'b10), "i_exec");
      cyc(0, 1, JUNK, 0, 0, 0, RW | PCW | ASRC | BSY | fld(4'b1100, 2'b10), "i_wb");

      // load with two data-memory wait cycles
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "ld_fetch");
      cyc(0, 1, 7'b0000011, 0, 0, 0, BSY | DEF, "ld_decode");
      cyc(0, 1, JUNK, 0, 0, 1, ASRC | BSY | fld(4'b1110, 2'b10), "ld_exec");
      cyc(0, 1, JUNK, 0, 0, 0, MR | ASRC | BSY | fld(4'b1110, 2'b10), "ld_mem0");
      cyc(0, 1, JUNK, 0, 0, 0, MR | ASRC | BSY | fld(4'b1110, 2'b10), "ld_mem1");
      cyc(0, 1, JUNK, 0, 0, 1, MR | ASRC | BSY | fld(4'b1110, 2'b10), "ld_mem2");
      cyc(0, 1, JUNK, 0, 0, 0, RW | M2R | PCW | ASRC | BSY | fld(4'b1110, 2'b10), "ld_wb");

      // branch taken, then not taken
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "bt_fetch");
      cyc(0, 1, 7'b1100011, 0, 0, 0, BSY | DEF, "bt_decode");
      cyc(0, 1, JUNK, 1, 0, 0, BR | PCW | PCS | BSY | fld(4'b1111, 2'b10), "bt_exec");
      cyc(0, 1, JUNK, 1, 1, 0, IMR | IRW | BSY | DEF, "bn_fetch");
      cyc(0, 1, 7'b1100011, 1, 0, 0, BSY | DEF, "bn_decode");
      cyc(0, 1, JUNK, 0, 0, 0, BR | PCW | BSY | fld(4'b1111, 2'b10), "bn_exec");

      // illegal opcode, first decode cycle frozen by en=0
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "ill_fetch");
      cyc(0, 0, 7'b1111111, 0, 0, 0, BSY | DEF, "ill_decode_frozen");
      cyc(0, 1, 7'b1111111, 0, 0, 0, ILL | PCW | BSY | DEF, "ill_decode");

      // store with en=0 while dmem_ready is already high
      cyc(0, 1, JUNK, 0, 1, 1, IMR | IRW | BSY | DEF, "st_fetch");
      cyc(0, 1, 7'b0100011, 0, 0, 1, BSY | DEF, "st_decode");
      cyc(0, 1, JUNK, 0, 0, 1, ASRC | BSY | fld(4'b0001, 2'b10), "st_exec");
      cyc(0, 0, JUNK, 0, 0, 1, ASRC | BSY | fld(4'b0001, 2'b10), "st_mem_hold0");
      cyc(0, 0, JUNK, 0, 0, 1, ASRC | BSY | fld(4'b0001, 2'b10), "st_mem_hold1");
      cyc(0, 1, JUNK, 0, 0, 1, MW | PCW | ASRC | BSY | fld(4'b0001, 2'b10), "st_mem");

      // LUI aborted by reset in WB
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "lui_fetch");
      cyc(0, 1, 7'b0110111, 0, 0, 0, BSY | DEF, "lui_decode");
      cyc(0, 1, JUNK, 0, 0, 0, ASRC | BSY | fld(4'b0011, 2'b01), "lui_exec");
      cyc(1, 1, JUNK, 0, 1, 1, 18'h0, "lui_wb_reset");

      // AUIPC straight after reset
      cyc(0, 1, JUNK, 0, 1, 0, IMR | IRW | BSY | DEF, "au_fetch");
      cyc(0, 1, 7'b0010111, 0, 0, 0, BSY | DEF, "au_decode");
      cyc(0, 1, JUNK, 0, 0, 0, ASRC | BSY | fld(4'b0111, 2'b00), "au_exec");
      cyc(0, 1, JUNK, 0, 0, 0, RW | PCW | ASRC | BSY | fld(4'b0111, 2'b00), "au_wb");
      cyc(0, 1, JUNK, 0, 0, 0, IMR | DEF, "au_next_fetch");

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
